// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by fetch, decode and immediate generation.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0: the canonical bubble
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // One fetched instruction together with the address it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [6:0] opcode_of(input logic [XLEN-1:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; clear wins over push and pop.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i & ~clear_i & (count_q != '0);
    assign do_push = push_i & ~clear_i & ((count_q != FULL) | do_pop);

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care until counted
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// RV32I fetch front end: PC, credit-limited imem requests, response
// buffering, stale-fetch dropping after redirects, and the IF/ID register.
module instruction_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic [6:0]  if_id_opcode
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          if_id_valid_q, if_id_valid_d;
    logic [31:0]   if_id_pc_q, if_id_pc_d;
    logic [31:0]   if_id_instr_q, if_id_instr_d;

    logic [CW-1:0] pcq_count, iq_count;
    logic [31:0]   pcq_rdata;
    fetch_entry_t  iq_wdata, iq_rdata;
    logic [CW:0]   in_use;
    logic          req_fire, rsp_take, rsp_drop, rsp_keep;
    logic          pcq_pop, iq_push, iq_pop;
    logic          unused_redirect_lsbs;

    // Credits cover both fetches in flight and words waiting for decode
    assign in_use         = {1'b0, out_q} + {1'b0, iq_count};
    assign imem_req_valid = rst_n & ~redirect_valid & (in_use < (CW+1)'(DEPTH));
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored
    assign rsp_take = imem_rsp_valid & (out_q != '0);
    assign rsp_drop = rsp_take & (drop_q != '0);
    assign rsp_keep = rsp_take & (drop_q == '0);

    assign pcq_pop  = rsp_keep & (pcq_count != '0);
    assign iq_push  = rsp_keep & ~redirect_valid;
    assign iq_pop   = ~redirect_valid & ~stall_i & (iq_count != '0);
    assign iq_wdata = '{pc: pcq_rdata, instr: imem_rsp_data};

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (redirect_valid),
        .push_i  (req_fire),
        .wdata_i (pc_q),
        .pop_i   (pcq_pop),
        .rdata_o (pcq_rdata),
        .count_o (pcq_count)
    );

    fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_instr_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (redirect_valid),
        .push_i  (iq_push),
        .wdata_i (iq_wdata),
        .pop_i   (iq_pop),
        .rdata_o (iq_rdata),
        .count_o (iq_count)
    );

    // PC, credit/drop bookkeeping and IF/ID next-state; redirect beats stall
    always_comb begin
        pc_d          = pc_q;
        out_d         = out_q + CW'(req_fire) - CW'(rsp_take);
        drop_d        = drop_q - CW'(rsp_drop);
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;

        if (req_fire) pc_d = pc_q + 32'd4;

        if (redirect_valid) begin
            // every fetch still outstanding after this cycle belongs to the old stream
            pc_d          = {redirect_pc[31:2], 2'b00};
            drop_d        = out_q - CW'(rsp_take);
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (!stall_i) begin
            if (iq_count != '0) begin
                if_id_valid_d = 1'b1;
                if_id_pc_d    = iq_rdata.pc;
                if_id_instr_d = iq_rdata.instr;
            end else begin
                if_id_valid_d = 1'b0;
                if_id_instr_d = NOP_INSTR;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            out_q         <= '0;
            drop_q        <= '0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= 32'h0;
            if_id_instr_q <= NOP_INSTR;
        end else begin
            pc_q          <= pc_d;
            out_q         <= out_d;
            drop_q        <= drop_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

    assign if_id_valid    = if_id_valid_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_q + 32'd4;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_opcode   = opcode_of(if_id_instr_q);

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench: in-order memory model plus a queue-level reference
// of the fetch stream, compared against the DUT every cycle.
module tb_instruction_fetch_stage;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic [6:0]  if_id_opcode;

    instruction_fetch_stage #(
        .RESET_PC  (RESET_PC),
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall_i        (stall_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr),
        .if_id_opcode   (if_id_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        pend[$];   // requests accepted by memory, not yet answered
    ent_t        buf_q[$];  // current-stream words fetched but not yet in IF/ID
    int          epoch;
    logic [31:0] m_req_pc;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int          n_assert;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0101_0101) ^ 32'hC0DE_0037;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check request side, advance model, check IF/ID.
    // rsp_mode: 0 = no response, 1 = answer oldest pending request,
    //           2 = assert rsp_valid regardless (spurious if nothing pending)
    task automatic step(input logic rst, input logic stall, input logic redir,
                        input logic [31:0] rpc, input logic rdy, input int rsp_mode);
        logic exp_rv;
        logic got;
        ent_t e;
        ent_t h;
        req_t r;
        @(negedge clk);
        rst_n          = rst;
        stall_i        = stall;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        if (rsp_mode != 0 && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            imem_rsp_valid = (rsp_mode == 2);
            imem_rsp_data  = $urandom;
        end
        #1;
        exp_rv = rst && !redir && (pend.size() + buf_q.size() < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_addr, m_req_pc);
        @(posedge clk);
        if (!rst) begin
            pend.delete();
            buf_q.delete();
            m_req_pc = RESET_PC;
            m_valid  = 1'b0;
            m_pc     = 32'h0;
            m_instr  = NOP;
        end else begin
            got = 1'b0;
            if (imem_rsp_valid && pend.size() > 0) begin
                r = pend.pop_front();
                if (r.epoch == epoch && !redir) begin
                    got     = 1'b1;
                    e.pc    = r.addr;
                    e.instr = mem_word(r.addr);
                end
            end
            if (redir) begin
                buf_q.delete();
                epoch++;
                m_req_pc = {rpc[31:2], 2'b00};
                m_valid  = 1'b0;
                m_instr  = NOP;
            end else begin
                if (!stall) begin
                    if (buf_q.size() > 0) begin
                        h       = buf_q.pop_front();
                        m_valid = 1'b1;
                        m_pc    = h.pc;
                        m_instr = h.instr;
                    end else begin
                        m_valid = 1'b0;
                        m_instr = NOP;
                    end
                end
                if (got) buf_q.push_back(e);
                if (exp_rv && rdy) begin
                    pend.push_back('{addr: m_req_pc, epoch: epoch});
                    m_req_pc = m_req_pc + 32'd4;
                end
            end
        end
        #1;
        chk("if_id_valid",    32'(if_id_valid), 32'(m_valid));
        chk("if_id_pc",       if_id_pc, m_pc);
        chk("if_id_pc_plus4", if_id_pc_plus4, m_pc + 32'd4);
        chk("if_id_instr",    if_id_instr, m_instr);
        chk("if_id_opcode",   32'(if_id_opcode), {25'b0, m_instr[6:0]});
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        epoch          = 0;
        m_req_pc       = RESET_PC;
        m_valid        = 1'b0;
        m_pc           = 32'h0;
        m_instr        = NOP;
        rst_n          = 1'b0;
        stall_i        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        // reset, with noise on the response port
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2);

        // streaming, memory answers one cycle after issue
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);

        // decode stall for five cycles, then release
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);

        // build up fetches in flight, redirect to an unaligned target
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b1, 0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);

        // redirect together with stall
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);

        // PC wrap past the top of the address space
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);

        // drain, then responses with nothing outstanding
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2);

        // reset mid-stream with responses pending, late responses afterwards
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        r_rst, r_stall, r_redir, r_rdy;
            logic [31:0] r_pc;
            int          r_mode, roll;
            r_rst   = ($urandom_range(0, 99) != 0);
            r_stall = ($urandom_range(0, 3) == 0);
            r_redir = ($urandom_range(0, 19) == 0);
            r_rdy   = ($urandom_range(0, 9) < 7);
            r_pc    = $urandom;
            roll    = $urandom_range(0, 99);
            r_mode  = (roll < 60) ? 1 : ((roll < 63) ? 2 : 0);
            step(r_rst, r_stall, r_redir, r_pc, r_rdy, r_mode);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
